riscv_result_checker: RTL and testbench

//  Synthesizable, parametrised result checker that sits beside the riscv core.
//  - Snoops the register-file and data-memory write ports.
//  - After a halt or a cycle timeout, compares up to N_CHECKS programmed expectations.
//  - Reports pass/fail, mismatch count and first failing entry.
//  - Replaces fixed end-of-run display checks with a self-checking block usable in sim and on FPGA.

---
 rtl/riscv_result_checker.sv | 237 +++++++++++++++++++++++
 tb/tb_riscv_result_checker.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_result_checker.sv
// riscv_result_checker: snoops the register-file and data-memory write ports of
// the core and, after halt or a cycle timeout, compares the captured values
// against up to N_CHECKS programmed expectations (one entry per cycle).
// Optional feature macro: RESULT_CHK_WRITTEN_EN -- each entry keeps a flag
// recording whether any matching write was seen during the run; a valid entry
// that was never written then counts as a mismatch.
module riscv_result_checker #(
    parameter int XLEN       = 32,
    parameter int N_CHECKS   = 8,
    parameter int MAX_CYCLES = 25,
    parameter int DM_AW      = 7,
    localparam int IDX_W     = (N_CHECKS > 1) ? $clog2(N_CHECKS) : 1,
    localparam int CNT_W     = $clog2(N_CHECKS + 1),
    localparam int CYC_W     = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic             cfg_kind,
    input  logic [DM_AW-1:0] cfg_addr,
    input  logic [XLEN-1:0]  cfg_exp,
    input  logic [XLEN-1:0]  cfg_mask,
    input  logic             start,
    input  logic             halt,
    input  logic             rf_we,
    input  logic [4:0]       rf_waddr,
    input  logic [XLEN-1:0]  rf_wdata,
    input  logic             dm_we,
    input  logic [DM_AW-1:0] dm_addr,
    input  logic [3:0]       dm_be,
    input  logic [XLEN-1:0]  dm_wdata,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timed_out,
    output logic [CNT_W-1:0] mism_cnt,
    output logic [IDX_W-1:0] fail_idx
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Expectation table
    logic [N_CHECKS-1:0] valid_q;
    logic [N_CHECKS-1:0] kind_q;
    logic [DM_AW-1:0]    addr_q [N_CHECKS];
    logic [XLEN-1:0]     exp_q  [N_CHECKS];
    logic [XLEN-1:0]     mask_q [N_CHECKS];

    // Captured values and per-entry next values
    logic [XLEN-1:0]                   shadow_q [N_CHECKS];
    logic [N_CHECKS-1:0][XLEN-1:0]     shadow_nx;
    logic [N_CHECKS-1:0]               hit_nx;
`ifdef RESULT_CHK_WRITTEN_EN
    logic [N_CHECKS-1:0]               written_q;
`endif

    logic [CYC_W-1:0] cyc_q;
    logic [IDX_W-1:0] chk_idx_q;
    logic [CNT_W-1:0] mism_cnt_q;
    logic [IDX_W-1:0] fail_idx_q;
    logic             timed_out_q;

    logic run_entry;
    logic timeout_hit;
    logic chk_last;
    logic entry_fail;

    assign chk_last = (chk_idx_q == IDX_W'(N_CHECKS - 1));

    // Next-state logic; run_entry marks the edge that (re)enters RUN
    always_comb begin
        state_d     = state_q;
        run_entry   = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_RUN;
                    run_entry = 1'b1;
                end
            end
            S_RUN: begin
                if (halt) begin
                    state_d = S_CHECK;
                end else if (cyc_q == CYC_W'(MAX_CYCLES - 1)) begin
                    state_d     = S_CHECK;
                    timeout_hit = 1'b1;
                end
            end
            S_CHECK: begin
                if (chk_last) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Expectation programming, accepted only while idle
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            kind_q  <= '0;
            for (int i = 0; i < N_CHECKS; i++) begin
                addr_q[i] <= '0;
                exp_q[i]  <= '0;
                mask_q[i] <= '0;
            end
        end else if (state_q == S_IDLE && cfg_we && int'(cfg_idx) < N_CHECKS) begin
            valid_q[cfg_idx] <= 1'b1;
            kind_q[cfg_idx]  <= cfg_kind;
            addr_q[cfg_idx]  <= cfg_addr;
            exp_q[cfg_idx]   <= cfg_exp;
            mask_q[cfg_idx]  <= cfg_mask;
        end
    end

    // Per-entry snoop match: register entries take whole words, memory entries
    // merge individual bytes whose wrapped byte address lands inside the word.
    for (genvar gi = 0; gi < N_CHECKS; gi++) begin : g_entry
        logic [XLEN-1:0] sh_d;
        logic            hit;

        // Compute the value this entry would capture at the coming edge
        always_comb begin
            sh_d = shadow_q[gi];
            hit  = 1'b0;
            if (valid_q[gi]) begin
                if (!kind_q[gi]) begin
                    if (rf_we && rf_waddr != 5'd0 && rf_waddr == addr_q[gi][4:0]) begin
                        sh_d = rf_wdata;
                        hit  = 1'b1;
                    end
                end else if (dm_we) begin
                    for (int j = 0; j < 4; j++) begin
                        for (int k = 0; k < 4; k++) begin
                            if (dm_be[k] &&
                                (dm_addr + DM_AW'(k)) == (addr_q[gi] + DM_AW'(j))) begin
                                sh_d[8*j +: 8] = dm_wdata[8*k +: 8];
                                hit            = 1'b1;
                            end
                        end
                    end
                end
            end
        end

        assign shadow_nx[gi] = sh_d;
        assign hit_nx[gi]    = hit;
    end

    // Shadow capture during RUN, cleared on every run entry
    always_ff @(posedge clk) begin
        if (reset || run_entry) begin
            for (int i = 0; i < N_CHECKS; i++) begin
                shadow_q[i] <= '0;
            end
        end else if (state_q == S_RUN) begin
            for (int i = 0; i < N_CHECKS; i++) begin
                if (hit_nx[i]) begin
                    shadow_q[i] <= shadow_nx[i];
                end
            end
        end
    end

`ifdef RESULT_CHK_WRITTEN_EN
    // Written flags: set by any matching write in RUN
    always_ff @(posedge clk) begin
        if (reset || run_entry) begin
            written_q <= '0;
        end else if (state_q == S_RUN) begin
            written_q <= written_q | hit_nx;
        end
    end
`endif

    // Compare the entry currently addressed by the check index
    always_comb begin
        entry_fail = valid_q[chk_idx_q] &&
                     (((shadow_q[chk_idx_q] ^ exp_q[chk_idx_q]) & mask_q[chk_idx_q]) != '0);
`ifdef RESULT_CHK_WRITTEN_EN
        if (valid_q[chk_idx_q] && !written_q[chk_idx_q]) begin
            entry_fail = 1'b1;
        end
`endif
    end

    // Run-cycle counter, check sequencing and result accumulation
    always_ff @(posedge clk) begin
        if (reset || run_entry) begin
            cyc_q       <= '0;
            chk_idx_q   <= '0;
            mism_cnt_q  <= '0;
            fail_idx_q  <= '0;
            timed_out_q <= 1'b0;
        end else if (state_q == S_RUN) begin
            cyc_q <= cyc_q + CYC_W'(1);
            if (timeout_hit) begin
                timed_out_q <= 1'b1;
            end
        end else if (state_q == S_CHECK) begin
            chk_idx_q <= chk_last ? '0 : chk_idx_q + IDX_W'(1);
            if (entry_fail) begin
                mism_cnt_q <= mism_cnt_q + CNT_W'(1);
                if (mism_cnt_q == '0) begin
                    fail_idx_q <= chk_idx_q;
                end
            end
        end
    end

    assign busy      = (state_q == S_RUN) || (state_q == S_CHECK);
    assign done      = (state_q == S_DONE);
    assign pass      = done && (mism_cnt_q == '0) && !timed_out_q;
    assign timed_out = timed_out_q;
    assign mism_cnt  = mism_cnt_q;
    assign fail_idx  = fail_idx_q;

endmodule

// File: tb/tb_riscv_result_checker.sv
// Self-checking bench for riscv_result_checker: directed scenarios plus
// randomized runs compared against a register-file / byte-memory image model.
module tb_riscv_result_checker;
    localparam int XLEN       = 32;
    localparam int N_CHECKS   = 8;
    localparam int MAX_CYCLES = 25;
    localparam int DM_AW      = 7;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_we;
    logic [2:0]  cfg_idx;
    logic        cfg_kind;
    logic [6:0]  cfg_addr;
    logic [31:0] cfg_exp;
    logic [31:0] cfg_mask;
    logic        start;
    logic        halt;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        dm_we;
    logic [6:0]  dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata;
    logic        busy;
    logic        done;
    logic        pass;
    logic        timed_out;
    logic [3:0]  mism_cnt;
    logic [2:0]  fail_idx;

    riscv_result_checker #(
        .XLEN(XLEN), .N_CHECKS(N_CHECKS), .MAX_CYCLES(MAX_CYCLES), .DM_AW(DM_AW)
    ) dut (
        .clk(clk), .reset(reset),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_kind(cfg_kind), .cfg_addr(cfg_addr),
        .cfg_exp(cfg_exp), .cfg_mask(cfg_mask),
        .start(start), .halt(halt),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be), .dm_wdata(dm_wdata),
        .busy(busy), .done(done), .pass(pass), .timed_out(timed_out),
        .mism_cnt(mism_cnt), .fail_idx(fail_idx)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: expectation table plus register-file and byte-memory images
    bit          m_valid [N_CHECKS];
    bit          m_kind  [N_CHECKS];
    logic [6:0]  m_addr  [N_CHECKS];
    logic [31:0] m_exp   [N_CHECKS];
    logic [31:0] m_mask  [N_CHECKS];
    logic [31:0] m_reg    [32];
    bit          m_reg_wr [32];
    logic [7:0]  m_mem    [128];
    bit          m_mem_wr [128];

    // Directed per-cycle write script
    int          dir_n = 0;
    logic        d_rf_we   [32];
    logic [4:0]  d_rf_addr [32];
    logic [31:0] d_rf_data [32];
    logic        d_dm_we   [32];
    logic [6:0]  d_dm_addr [32];
    logic [3:0]  d_dm_be   [32];
    logic [31:0] d_dm_data [32];
    bit          jam_cfg = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cfg_we = 0; cfg_idx = 0; cfg_kind = 0; cfg_addr = 0; cfg_exp = 0; cfg_mask = 0;
        start = 0; halt = 0;
        rf_we = 0; rf_waddr = 0; rf_wdata = 0;
        dm_we = 0; dm_addr = 0; dm_be = 0; dm_wdata = 0;
    endtask

    task automatic clear_dir();
        dir_n = 0;
        for (int i = 0; i < 32; i++) begin
            d_rf_we[i] = 0; d_rf_addr[i] = 0; d_rf_data[i] = 0;
            d_dm_we[i] = 0; d_dm_addr[i] = 0; d_dm_be[i] = 0; d_dm_data[i] = 0;
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        tick();
        reset = 0;
        for (int i = 0; i < N_CHECKS; i++) m_valid[i] = 0;
    endtask

    task automatic cfg_entry(input int idx, input bit kind, input logic [6:0] addr,
                             input logic [31:0] exp, input logic [31:0] mask);
        cfg_we = 1; cfg_idx = 3'(idx); cfg_kind = kind; cfg_addr = addr;
        cfg_exp = exp; cfg_mask = mask;
        tick();
        cfg_we = 0;
        m_valid[idx] = 1; m_kind[idx] = kind; m_addr[idx] = addr;
        m_exp[idx] = exp; m_mask[idx] = mask;
    endtask

    function automatic logic [31:0] pool();
        case ($urandom % 5)
            0: return 32'h0000_000F;
            1: return 32'h0000_0007;
            2: return 32'h0F0F_0F0F;
            3: return 32'h0000_0000;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [6:0] pick_maddr();
        if ($urandom % 2) return 7'($urandom_range(0, 7));
        return 7'(124 + $urandom_range(0, 3));
    endfunction

    // One run: start, drive cycles (halt on run cycle h, or none if h >= MAX_CYCLES),
    // then wait for done and compare all results against the model.
    task automatic run(input int h, input bit rnd, input int stop_in_check, input string tag);
        int lat;
        int em;
        int ef;
        logic [31:0] sh;
        bit wr;
        bit fl;
        bit etimed;
        logic [6:0] a;
        start = 1;
        tick();
        start = 0;
        chk({tag, "_busy_run"}, busy, 1);
        for (int i = 0; i < 32; i++) begin m_reg[i] = 0; m_reg_wr[i] = 0; end
        for (int i = 0; i < 128; i++) begin m_mem[i] = 0; m_mem_wr[i] = 0; end
        for (int c = 0; c < MAX_CYCLES; c++) begin
            if (rnd) begin
                rf_we = 1'($urandom); rf_waddr = 5'($urandom_range(0, 7)); rf_wdata = pool();
                dm_we = 1'($urandom); dm_addr = pick_maddr(); dm_be = 4'($urandom);
                dm_wdata = pool();
                start = ($urandom % 5 == 0);
                jam_cfg = ($urandom % 3 == 0);
            end else if (c < dir_n) begin
                rf_we = d_rf_we[c]; rf_waddr = d_rf_addr[c]; rf_wdata = d_rf_data[c];
                dm_we = d_dm_we[c]; dm_addr = d_dm_addr[c]; dm_be = d_dm_be[c];
                dm_wdata = d_dm_data[c];
            end else begin
                rf_we = 0; dm_we = 0;
            end
            if (jam_cfg) begin
                cfg_we = 1; cfg_idx = 3'($urandom); cfg_kind = 1'($urandom);
                cfg_addr = 0; cfg_exp = 32'hFFFF_FFFF; cfg_mask = 32'hFFFF_FFFF;
            end else begin
                cfg_we = 0;
            end
            halt = (c == h);
            if (rf_we && rf_waddr != 0) begin
                m_reg[rf_waddr] = rf_wdata;
                m_reg_wr[rf_waddr] = 1;
            end
            if (dm_we) begin
                for (int k = 0; k < 4; k++) begin
                    if (dm_be[k]) begin
                        a = 7'(dm_addr + k);
                        m_mem[a] = dm_wdata[8*k +: 8];
                        m_mem_wr[a] = 1;
                    end
                end
            end
            tick();
            if (c == h) break;
        end
        idle_inputs();
        if (rnd) jam_cfg = 0;
        if (stop_in_check > 0) begin
            repeat (stop_in_check) tick();
            return;
        end
        lat = 1;
        while (!done && lat < 200) begin
            tick();
            lat++;
        end
        em = 0; ef = 0;
        for (int i = 0; i < N_CHECKS; i++) begin
            if (m_valid[i]) begin
                if (!m_kind[i]) begin
                    sh = m_reg[m_addr[i][4:0]];
                    wr = m_reg_wr[m_addr[i][4:0]];
                end else begin
                    wr = 0;
                    for (int j = 0; j < 4; j++) begin
                        a = 7'(m_addr[i] + j);
                        sh[8*j +: 8] = m_mem[a];
                        wr = wr | m_mem_wr[a];
                    end
                end
                fl = (((sh ^ m_exp[i]) & m_mask[i]) != 0);
`ifdef RESULT_CHK_WRITTEN_EN
                fl = fl | !wr;
`endif
                if (fl) begin
                    if (em == 0) ef = i;
                    em++;
                end
            end
        end
        etimed = (h >= MAX_CYCLES);
        $display("run %s: halt_cycle=%0d done=%0d pass=%0d timed_out=%0d mism=%0d fail_idx=%0d lat=%0d",
                 tag, h, done, pass, timed_out, mism_cnt, fail_idx, lat);
        chk({tag, "_latency"}, lat, N_CHECKS + 1);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy_done"}, busy, 0);
        chk({tag, "_timed_out"}, timed_out, 32'(etimed));
        chk({tag, "_mism_cnt"}, mism_cnt, em);
        chk({tag, "_fail_idx"}, fail_idx, ef);
        chk({tag, "_pass"}, pass, 32'((em == 0) && !etimed));
    endtask

    initial begin
        idle_inputs();
        clear_dir();
        reset = 1;
        tick();
        tick();
        reset = 0;
        for (int i = 0; i < N_CHECKS; i++) m_valid[i] = 0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_timed_out", timed_out, 0);
        chk("rst_mism_cnt", mism_cnt, 0);
        chk("rst_fail_idx", fail_idx, 0);

        // Register entry matched by a single write
        do_reset(); clear_dir();
        cfg_entry(0, 0, 7'd5, 32'h07, 32'hFF);
        dir_n = 1; d_rf_we[0] = 1; d_rf_addr[0] = 5; d_rf_data[0] = 32'h7;
        run(1, 0, 0, "t1");
        chk("t1_pass_const", pass, 1);
        chk("t1_mism_const", mism_cnt, 0);

        // Memory entry, low byte lane
        do_reset(); clear_dir();
        cfg_entry(3, 1, 7'd4, 32'h0F, 32'h0000_00FF);
        dir_n = 1; d_dm_we[0] = 1; d_dm_addr[0] = 4; d_dm_be[0] = 4'b0001; d_dm_data[0] = 32'h0F;
        run(1, 0, 0, "t2a");
        chk("t2a_pass_const", pass, 1);
        do_reset();
        cfg_entry(3, 1, 7'd4, 32'h0F, 32'h0000_00FF);
        d_dm_data[0] = 32'h1F;
        run(1, 0, 0, "t2b");
        chk("t2b_pass_const", pass, 0);
        chk("t2b_fail_idx_const", fail_idx, 3);

        // Entries 2 and 5 wrong
        do_reset(); clear_dir();
        dir_n = 6;
        for (int i = 0; i < 6; i++) begin
            cfg_entry(i, 0, 7'(i + 1), 32'h10 + i, 32'hFFFF_FFFF);
            d_rf_we[i] = 1; d_rf_addr[i] = 5'(i + 1);
            d_rf_data[i] = (i == 2 || i == 5) ? 32'h99 : 32'h10 + i;
        end
        run(6, 0, 0, "t3");
        chk("t3_mism_const", mism_cnt, 2);
        chk("t3_fail_idx_const", fail_idx, 2);

        // Timeout, then halt on the last allowed cycle (restart from DONE)
        do_reset(); clear_dir();
        cfg_entry(0, 0, 7'd5, 32'h07, 32'hFFFF_FFFF);
        dir_n = 1; d_rf_we[0] = 1; d_rf_addr[0] = 5; d_rf_data[0] = 32'h7;
        run(99, 0, 0, "t4a");
        chk("t4a_timed_const", timed_out, 1);
        chk("t4a_pass_const", pass, 0);
        run(24, 0, 0, "t4b");
        chk("t4b_timed_const", timed_out, 0);
        chk("t4b_pass_const", pass, 1);

        // x0 writes never match; cfg_we during RUN ignored
        do_reset(); clear_dir();
        cfg_entry(0, 0, 7'd0, 32'h0, 32'hFFFF_FFFF);
        dir_n = 1; d_rf_we[0] = 1; d_rf_addr[0] = 0; d_rf_data[0] = 32'hFFFF_FFFF;
        jam_cfg = 1;
        run(2, 0, 0, "t5");
        jam_cfg = 0;
`ifdef RESULT_CHK_WRITTEN_EN
        chk("t5_pass_const", pass, 0);
`else
        chk("t5_pass_const", pass, 1);
`endif

        // Reset in the middle of CHECK
        do_reset(); clear_dir();
        cfg_entry(0, 0, 7'd1, 32'h1, 32'hFFFF_FFFF);
        cfg_entry(1, 0, 7'd2, 32'h1, 32'hFFFF_FFFF);
        run(0, 0, 3, "t6");
        chk("t6_busy_check", busy, 1);
        chk("t6_mism_mid", mism_cnt, 2);
        reset = 1;
        tick();
        reset = 0;
        for (int i = 0; i < N_CHECKS; i++) m_valid[i] = 0;
        chk("t6_busy_after_rst", busy, 0);
        chk("t6_done_after_rst", done, 0);
        chk("t6_mism_after_rst", mism_cnt, 0);
        run(1, 0, 0, "t6b");
        chk("t6b_pass_const", pass, 1);
`ifdef RESULT_CHK_WRITTEN_EN
        do_reset(); clear_dir();
        cfg_entry(4, 0, 7'd9, 32'h0, 32'hFF);
        run(0, 0, 0, "t6c");
        chk("t6c_pass_const", pass, 0);
`endif

        // Randomized runs, sometimes restarting from DONE without reprogramming
        for (int it = 0; it < 40; it++) begin
            if (it == 0 || ($urandom % 3) != 0) begin
                do_reset();
                for (int n = $urandom_range(1, N_CHECKS); n > 0; n--) begin
                    automatic bit kd = 1'($urandom);
                    automatic logic [31:0] mk;
                    case ($urandom % 4)
                        0: mk = 32'hFFFF_FFFF;
                        1: mk = 32'h0000_00FF;
                        2: mk = 32'h0;
                        default: mk = $urandom;
                    endcase
                    cfg_entry($urandom_range(0, N_CHECKS - 1), kd,
                              kd ? pick_maddr() : 7'($urandom_range(0, 7)), pool(), mk);
                end
            end
            run($urandom_range(0, 30), 1, 0, $sformatf("rnd%0d", it));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
